// File: rtl/tdoa_event_reader.sv
// tdoa_event_reader: captures completed TDoA trigger-time events into a FIFO and re-arms the TDoA block.
// An Avalon-MM slave in the pcm_clk domain exposes the events, time differences, status and interrupt.
module tdoa_event_reader #(
   parameter int DEPTH          = 8,
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        pcm_clk,
   input  logic        reset,
   input  logic [31:0] trigger_time_1,
   input  logic [31:0] trigger_time_2,
   input  logic [31:0] trigger_time_3,
   output logic        tdoa_reset,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   typedef enum logic [1:0] {REARM, WAITCLR, ARMED, PUSH} state_t;
   typedef struct packed {
      logic [31:0] t1;
      logic [31:0] t2;
      logic [31:0] t3;
      logic [7:0]  seq;
   } entry_t;
   state_t        state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [TW-1:0] idle_q, idle_d;
   entry_t        cap_q, cap_d, head;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    seq_q, seq_d, wdog_q, wdog_d;
   logic          ovf_q, ovf_d, irq_en_q, irq_en_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          any, ctrl_wr, force_rearm, pop, push, unused_wd;
   always_comb begin
      any         = |{trigger_time_1, trigger_time_2, trigger_time_3};
      ctrl_wr     = write && address == 3'd6;
      force_rearm = ctrl_wr && writedata[2] && state_q != PUSH;
      pop         = write && address == 3'd7 && cnt_q != '0;
      // a pop in the same cycle frees the slot the push needs
      push        = state_q == PUSH && (cnt_q != CW'(DEPTH) || pop);
      head        = mem_q[rp_q];
      unused_wd   = ^writedata[31:3];
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      idle_d      = idle_q;
      cap_d       = cap_q;
      seq_d       = seq_q;
      mem_d       = mem_q;
      wp_d        = wp_q;
      rp_d        = pop ? rp_q + AW'(1) : rp_q;
      cnt_d       = cnt_q + CW'(push) - CW'(pop);
      ovf_d       = ovf_q && !(ctrl_wr && writedata[1]);
      wdog_d      = (ctrl_wr && writedata[1]) ? '0 : wdog_q;
      irq_en_d    = ctrl_wr ? writedata[0] : irq_en_q;
      if (force_rearm) begin
         state_d = REARM;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            REARM: begin
               rcnt_d  = rcnt_q == RW'(RESET_CYCLES - 1) ? '0 : rcnt_q + RW'(1);
               state_d = rcnt_q == RW'(RESET_CYCLES - 1) ? WAITCLR : REARM;
            end
            WAITCLR: state_d = any ? WAITCLR : ARMED;
            ARMED:
               if (any) begin
                  cap_d   = {trigger_time_1, trigger_time_2, trigger_time_3, seq_q};
                  seq_d   = seq_q + 8'd1;
                  state_d = PUSH;
               end else if (TIMEOUT_CYCLES != 0 && idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_d = REARM;
                  wdog_d  = wdog_q + {7'd0, wdog_q != 8'hFF};
               end else begin
                  idle_d = idle_q + TW'(1);
               end
            default: begin
               state_d = REARM;
               if (push) begin
                  mem_d[wp_q] = cap_q;
                  wp_d        = wp_q + AW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         endcase
      end
      if (state_d != ARMED) idle_d = '0;
      rdata_d = '0;
      if (read) begin
         case (address)
            3'd0:    rdata_d = {wdog_q, head.seq, 1'b0, 7'(cnt_q), 5'd0, state_q == ARMED, ovf_q, cnt_q != '0};
            3'd1:    rdata_d = head.t1;
            3'd2:    rdata_d = head.t2;
            3'd3:    rdata_d = head.t3;
            3'd4:    rdata_d = head.t2 - head.t1;
            3'd5:    rdata_d = head.t3 - head.t1;
            3'd6:    rdata_d = {31'd0, irq_en_q};
            default: rdata_d = '0;
         endcase
      end
   end
   always_ff @(posedge pcm_clk or posedge reset) begin
      if (reset) begin
         state_q  <= REARM;
         rcnt_q   <= '0;
         idle_q   <= '0;
         cap_q    <= '0;
         seq_q    <= '0;
         mem_q    <= '{default: '0};
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         wdog_q   <= '0;
         irq_en_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         idle_q   <= idle_d;
         cap_q    <= cap_d;
         seq_q    <= seq_d;
         mem_q    <= mem_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         wdog_q   <= wdog_d;
         irq_en_q <= irq_en_d;
         rdata_q  <= rdata_d;
      end
   end
   assign tdoa_reset = state_q == REARM;
   assign readdata   = rdata_q;
   assign irq        = irq_en_q && (cnt_q != '0 || ovf_q);
endmodule

// File: tb/tb_tdoa_event_reader.sv
// tb_tdoa_event_reader: directed and randomized checks of tdoa_event_reader against a queue-based model.
module tb_tdoa_event_reader;
   localparam int DEPTH = 8;
   localparam int RC    = 4;
   typedef struct {
      logic [31:0] a, b, c;
      logic [7:0]  s;
   } ev_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, rd, wr, w_rd, w_wr, tr, irq, w_tr, w_irq;
   logic [31:0] t1, t2, t3, wd, w_wd, rdata, w_rdata;
   logic [2:0]  addr, w_addr;
   tdoa_event_reader #(.DEPTH(DEPTH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(0)) dut (
      .pcm_clk(clk), .reset(rst), .trigger_time_1(t1), .trigger_time_2(t2), .trigger_time_3(t3),
      .tdoa_reset(tr), .address(addr), .read(rd), .write(wr), .writedata(wd), .readdata(rdata), .irq(irq));
   tdoa_event_reader #(.DEPTH(DEPTH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(10)) dut_w (
      .pcm_clk(clk), .reset(rst), .trigger_time_1(32'd0), .trigger_time_2(32'd0), .trigger_time_3(32'd0),
      .tdoa_reset(w_tr), .address(w_addr), .read(w_rd), .write(w_wr), .writedata(w_wd), .readdata(w_rdata),
      .irq(w_irq));
   int errs = 0, checks = 0;
   int ph, rl;
   ev_t q[$];
   ev_t cap;
   bit ovf, ien;
   logic [7:0] seq;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask
   function automatic void model_reset();
      ph = 0;
      rl = RC;
      q.delete();
      ovf = 0;
      ien = 0;
      seq = 0;
   endfunction
   // one clock: predict read data from pre-edge state, advance the model, then compare
   task automatic tick();
      logic [31:0] er, em;
      bit any, pop, frc, rdq;
      ev_t h;
      any = (t1 | t2 | t3) != 0;
      pop = wr && addr == 3'd7 && q.size() > 0;
      frc = wr && addr == 3'd6 && wd[2];
      rdq = rd;
      er  = 0;
      em  = 0;
      h   = q.size() > 0 ? q[0] : '{0, 0, 0, 0};
      if (rd) begin
         case (addr)
            0: er = {8'h00, h.s, 1'b0, 7'(q.size()), 5'd0, ph == 2, ovf, q.size() > 0};
            1: er = h.a;
            2: er = h.b;
            3: er = h.c;
            4: er = h.b - h.a;
            5: er = h.c - h.a;
            6: er = {31'd0, ien};
            default: er = 0;
         endcase
         if (q.size() == 0) em = addr == 0 ? 32'h00FF0000 : (addr <= 5 ? 32'hFFFFFFFF : 32'h0);
      end
      @(posedge clk);
      if (wr && addr == 3'd6) begin
         ien = wd[0];
         if (wd[1]) ovf = 0;
      end
      if (pop) void'(q.pop_front());
      if (frc && ph != 3) begin
         ph = 0;
         rl = RC;
      end else begin
         case (ph)
            0: begin rl--; if (rl == 0) ph = 1; end
            1: if (!any) ph = 2;
            2: if (any) begin cap = '{t1, t2, t3, seq}; seq++; ph = 3; end
            default: begin
               if (q.size() < DEPTH) q.push_back(cap); else ovf = 1;
               ph = 0;
               rl = RC;
            end
         endcase
      end
      #1;
      check("tdoa_reset", tr, ph == 0);
      check("irq", irq, ien && (q.size() > 0 || ovf));
      if (rdq) check($sformatf("readdata[%0d]", addr), rdata & ~em, er & ~em);
   endtask
   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      rd = 1; addr = a;
      tick();
      d = rdata; rd = 0;
   endtask
   task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
      wr = 1; addr = a; wd = v;
      tick();
      wr = 0;
   endtask
   task automatic wait_armed();
      for (int i = 0; i < 50 && ph != 2; i++) tick();
      check("wait_armed", ph, 2);
   endtask
   task automatic event3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      t1 = a; t2 = b; t3 = c;
      tick();
      t1 = 0; t2 = 0; t3 = 0;
   endtask
   task automatic do_reset();
      rst = 1; t1 = 0; t2 = 0; t3 = 0; rd = 0; wr = 0; w_rd = 0; w_wr = 0;
      #1;
      check("rst_tdoa_reset", tr, 1);
      check("rst_irq", irq, 0);
      check("rst_readdata", rdata, 0);
      @(posedge clk);
      #1;
      model_reset();
      rst = 0;
   endtask
   initial begin
      logic [31:0] d;
      int hi, prev, hold, r;
      int rises[$];
      t1 = 0; t2 = 0; t3 = 0; rd = 0; wr = 0; wd = 0; addr = 0;
      w_rd = 0; w_wr = 0; w_wd = 0; w_addr = 0;
      do_reset();
      check("tr_pre", tr, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("tr_edge%0d", i), tr, i < 4);
      end
      tick();
      bus_read(0, d); check("status_idle", d, 32'h00000004);
      event3(100, 103, 97);
      tick();
      hi = 0;
      for (int i = 0; i < 20 && tr; i++) begin hi++; tick(); end
      check("pulse_len", hi, 4);
      bus_read(1, d); check("t1", d, 100);
      bus_read(2, d); check("t2", d, 103);
      bus_read(3, d); check("t3", d, 97);
      bus_read(4, d); check("t2_t1", d, 3);
      bus_read(5, d); check("t3_t1", d, 32'hFFFFFFFD);
      wait_armed();
      bus_read(0, d); check("status_one", d, 32'h00000105);
      bus_write(7, 0);
      bus_read(0, d); check("status_popped", d, 32'h00000004);
      bus_write(6, 32'h4);
      check("force_tr", tr, 1);
      wait_armed();
      event3(1, 2, 3);
      tick();
      bus_write(6, 1);
      bus_read(1, d); check("pre_reset_t1", d, 1);
      do_reset();
      wait_armed();
      bus_write(6, 1);
      for (int i = 0; i < 9; i++) begin
         wait_armed();
         event3(i + 1, i + 20, i + 300);
      end
      wait_armed();
      bus_read(0, d); check("status_full", d, 32'h00000807);
      check("irq_full", irq, 1);
      for (int i = 0; i < 8; i++) bus_write(7, 0);
      bus_read(0, d); check("status_drained", d, 32'h00000006);
      bus_write(6, 3);
      for (int i = 0; i < 8; i++) begin
         wait_armed();
         event3(i + 40, i + 41, 0);
      end
      wait_armed();
      event3(50, 60, 70);
      bus_write(7, 0);
      wait_armed();
      bus_read(0, d); check("status_pushpop", d, 32'h000A0805);
      for (int i = 0; i < 8; i++) bus_write(7, 0);
      wait_armed();
      t1 = 5; t2 = 6; t3 = 7;
      for (int i = 0; i < 12; i++) tick();
      bus_read(0, d); check("status_hold", d, 32'h00120101);
      t1 = 0; t2 = 0; t3 = 0;
      tick();
      bus_read(0, d); check("status_rearmed", d, 32'h00120105);
      do_reset();
      prev = 1;
      for (int n = 1; n <= 100 && rises.size() < 3; n++) begin
         tick();
         if (w_tr && !prev) rises.push_back(n);
         prev = w_tr;
      end
      check("wd_rises", rises.size(), 3);
      check("wd_first", rises.size() > 0 ? rises[0] : 0, 15);
      check("wd_period", rises.size() > 1 ? rises[1] - rises[0] : 0, 15);
      check("wd_period2", rises.size() > 2 ? rises[2] - rises[1] : 0, 15);
      w_rd = 1; w_addr = 0;
      tick();
      w_rd = 0;
      check("wd_status", w_rdata, 32'h03000000);
      w_wr = 1; w_addr = 6; w_wd = 2;
      tick();
      w_wr = 0; w_rd = 1; w_addr = 0;
      tick();
      w_rd = 0;
      check("wd_cleared", w_rdata, 32'h00000000);
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold > 0) hold--;
         else if ($urandom_range(5) == 0) begin
            t1 = $urandom_range(3) == 0 ? 32'd0 : $urandom;
            t2 = $urandom_range(3) == 0 ? 32'd0 : $urandom;
            t3 = 32'($urandom_range(100000, 1));
            hold = $urandom_range(4);
         end else begin
            t1 = 0; t2 = 0; t3 = 0;
         end
         r = $urandom_range(9);
         rd = 0; wr = 0;
         addr = 3'($urandom_range(7));
         if (r < 5) rd = 1;
         else if (r < 7) begin wr = 1; addr = 3'd7; rd = r == 6; end
         else if (r == 7) begin
            wr = 1; addr = 3'd6;
            wd = {29'd0, $urandom_range(20) == 0, $urandom_range(10) == 0, 1'($urandom_range(1))};
         end else if (r == 8) begin
            wr = 1; addr = 3'($urandom_range(5)); wd = $urandom;
         end
         tick();
      end
      rd = 0; wr = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
